// File: rtl/tick_arb_pkg.sv
// Shared definitions for the tick timer arbiter: FSM state encoding and
// default parameter values used by the top and the prescaler.
package tick_arb_pkg;

  localparam int DEF_FREQUENCY = 100_000_000;
  localparam int DEF_N_REQ     = 4;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-cycle prescaler: counts 0..FREQUENCY-1 while enabled and flags the
// last cycle of each period as a tick. A synchronous clear restarts the
// period so every granted operation begins with a full tick interval.
module tick_prescaler #(
  parameter int FREQUENCY = tick_arb_pkg::DEF_FREQUENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;
  localparam logic [PW-1:0] LAST = PW'(FREQUENCY - 1);

  logic [PW-1:0] count;

  // Period counter; clear takes priority over counting.
  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Tick is gated by en so it can never fire outside RUN.
  assign tick = en && (count == LAST);

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin arbiter sharing one tick timer among N_REQ requesters.
// The winner's delay (in ticks) is latched, counted down on each prescaler
// tick, and completion is signalled with a one-cycle done pulse to the owner.
// A zero delay skips RUN: DONE first shows the grant for one cycle, then
// issues the done pulse in its second cycle.
module tick_timer_arbiter
  import tick_arb_pkg::*;
#(
  parameter int FREQUENCY = DEF_FREQUENCY,
  parameter int N_REQ     = DEF_N_REQ,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] delay,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   tick
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic [CNT_W-1:0] win_delay;
  logic [CNT_W-1:0] remaining;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] owner_oh;
  logic             presc_clear;
  logic             presc_en;

  // Round-robin search starting just after the previous owner.
  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_owner) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_valid && req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_delay   = delay[int'(win_idx)*CNT_W +: CNT_W];
  assign win_oh      = N_REQ'(1) << win_idx;
  assign owner_oh    = N_REQ'(1) << owner;
  assign presc_clear = (state == IDLE) && win_valid;
  assign presc_en    = (state == RUN);

  tick_prescaler #(
    .FREQUENCY(FREQUENCY)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(presc_clear),
    .en   (presc_en),
    .tick (tick)
  );

  // Arbitration FSM with registered grant/done/busy and the tick countdown.
  // NOTE: all state, counters included, resets asynchronously so the outputs
  // drop the moment reset rises and any in-flight operation is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;
      remaining  <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner     <= win_idx;
            remaining <= win_delay;
            grant     <= win_oh;
            busy      <= 1'b1;
            state     <= (win_delay == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!req[owner]) begin
            // Owner withdrew: abort silently, it still counts as served.
            grant      <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
            state      <= IDLE;
          end else if (tick) begin
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              grant <= '0;
              done  <= owner_oh;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (done == '0) begin
            // Entered with zero delay: the grant cycle has been shown, pulse now.
            grant <= '0;
            done  <= owner_oh;
          end else begin
            done       <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with FREQUENCY=4, N_REQ=4, CNT_W=8.
// Cycle 0 of each scenario is the cycle in which req is first driven; the
// outputs {grant, done, tick, busy} are sampled on the falling edge.
module tb_tick_timer_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] delay;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        tick;

  int n_checks = 0;
  int n_fail   = 0;

  tick_timer_arbiter #(
    .FREQUENCY(4),
    .N_REQ    (4),
    .CNT_W    (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .delay(delay),
    .grant(grant),
    .done (done),
    .busy (busy),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog elapsed before the summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] ev(input logic [3:0] g, input logic [3:0] d,
                                    input logic t, input logic b);
    return {g, d, t, b};
  endfunction

  // Advance to just after the next rising edge (the start of the next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] obsv;
    reset = 1'b1;
    req   = '0;
    delay = '0;
    #1;
    obsv = {grant, done, tick, busy};
    if (obsv !== 10'b0) begin
      $display("FAIL reset_immediate got=%b exp=%b", obsv, 10'b0);
      n_fail++;
    end
    n_checks++;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    obsv = {grant, done, tick, busy};
    if (obsv !== 10'b0) begin
      $display("FAIL reset_released_idle got=%b exp=%b", obsv, 10'b0);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_single();
    logic [9:0] expv, obsv;
    step();
    delay = {8'd0, 8'd0, 8'd0, 8'd3};
    req   = 4'b0001;
    for (int c = 0; c <= 15; c++) begin
      if (c == 13) req = 4'b0000;
      @(negedge clk);
      expv = ev((c >= 1 && c <= 12) ? 4'b0001 : 4'b0000,
                (c == 13) ? 4'b0001 : 4'b0000,
                (c == 4 || c == 8 || c == 12),
                (c >= 1 && c <= 13));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL single c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_zero_delay();
    logic [9:0] expv, obsv;
    delay = {8'd7, 8'd0, 8'd7, 8'd7};
    req   = 4'b0100;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) req = 4'b0000;
      @(negedge clk);
      expv = ev((c == 1) ? 4'b0100 : 4'b0000,
                (c == 2) ? 4'b0100 : 4'b0000,
                1'b0,
                (c == 1 || c == 2));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL zero_delay c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_abort();
    logic [9:0] expv, obsv;
    logic [3:0] eg;
    delay = {8'd1, 8'd5, 8'd5, 8'd1};
    req   = 4'b0010;
    for (int c = 0; c <= 10; c++) begin
      if (c == 6) req = 4'b0000;
      if (c == 7) req = 4'b0101;
      if (c == 8) req = 4'b0000;
      @(negedge clk);
      eg   = (c >= 1 && c <= 6) ? 4'b0010 : ((c == 8) ? 4'b0100 : 4'b0000);
      expv = ev(eg, 4'b0000, (c == 4), ((c >= 1 && c <= 6) || c == 8));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL abort c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] expv, obsv;
    logic [3:0] oh;
    int         p;
    reset = 1'b1;
    step();
    reset = 1'b0;
    delay = {8'd1, 8'd1, 8'd1, 8'd1};
    req   = 4'b1111;
    for (int c = 0; c <= 30; c++) begin
      if (c == 29) req = 4'b0000;
      @(negedge clk);
      p    = c % 6;
      oh   = 4'b0001 << ((c / 6) % 4);
      expv = ev((p >= 1 && p <= 4) ? oh : 4'b0000,
                (p == 5) ? oh : 4'b0000,
                (p == 4),
                (p >= 1 && p <= 5));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL round_robin c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] expv, obsv;
    delay = {8'd0, 8'd0, 8'd0, 8'd4};
    req   = 4'b0001;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      expv = ev((c >= 1) ? 4'b0001 : 4'b0000, 4'b0000, (c == 4), (c >= 1));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL reset_mid_run_pre c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
    // Cycle 5: reset asserted between edges must clear outputs at once.
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    obsv = {grant, done, tick, busy};
    if (obsv !== 10'b0) begin
      $display("FAIL reset_mid_run_async got=%b exp=%b", obsv, 10'b0);
      n_fail++;
    end
    n_checks++;
    step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      obsv = {grant, done, tick, busy};
      if (obsv !== 10'b0) begin
        $display("FAIL reset_mid_run_quiet c=%0d got=%b exp=%b", c, obsv, 10'b0);
        n_fail++;
      end
      n_checks++;
      step();
    end
    delay = {8'd1, 8'd0, 8'd0, 8'd1};
    req   = 4'b1001;
    for (int c = 0; c <= 1; c++) begin
      @(negedge clk);
      expv = ev((c == 1) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, (c == 1));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL reset_restart c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_isolation();
    logic [9:0] expv, obsv;
    delay = {8'd2, 8'd0, 8'd0, 8'd3};
    req   = 4'b0001;
    for (int c = 0; c <= 14; c++) begin
      if (c >= 2 && c <= 10) begin
        req[3]      = c[0];
        delay[31:24] = 8'(c * 7);
      end
      if (c == 11) req[3] = 1'b0;
      if (c == 13) req = 4'b0000;
      @(negedge clk);
      expv = ev((c >= 1 && c <= 12) ? 4'b0001 : 4'b0000,
                (c == 13) ? 4'b0001 : 4'b0000,
                (c == 4 || c == 8 || c == 12),
                (c >= 1 && c <= 13));
      obsv = {grant, done, tick, busy};
      if (obsv !== expv) begin
        $display("FAIL isolation c=%0d grant/done/tick/busy got=%b exp=%b", c, obsv, expv);
        n_fail++;
      end
      n_checks++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_delay();
    test_abort();
    test_round_robin();
    test_reset_mid_run();
    test_isolation();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_timer_arbiter.md
TICK_TIMER_ARBITER -- requirements
Module: tick_timer_arbiter

Interface
REQ-001 Parameter FREQUENCY, default 100_000_000, is the number of clk cycles per tick.
REQ-002 Parameter N_REQ, default 4, is the number of requesters.
REQ-003 Parameter CNT_W, default 8, is the width of each requested delay in ticks.
REQ-004 clk  input  1  single system clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester level request for the shared timer.
REQ-007 delay  input  N_REQ*CNT_W  flattened per-requester delay in ticks; requester i occupies bits [i*CNT_W +: CNT_W].
REQ-008 grant  output  N_REQ  one-hot owner of the timer; all zero when idle.
REQ-009 done  output  N_REQ  one-cycle pulse to the owner on completion.
REQ-010 busy  output  1  high while in RUN or DONE.
REQ-011 tick  output  1  one-cycle pulse for each elapsed tick during RUN.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-013 In IDLE with any req bit high, the block SHALL select a winner round-robin, searching from (last_owner+1) mod N_REQ upward; after reset, last_owner = N_REQ-1, so requester 0 has first priority.
REQ-014 On the selection edge, the block SHALL:
- latch the winner's delay into remaining (CNT_W bits);
- assert grant for the winner;
- clear the prescaler to 0;
- enter RUN, or enter DONE directly when the latched delay is 0.
REQ-015 In RUN, the prescaler SHALL count 0..FREQUENCY-1 and wrap; tick SHALL be high in the cycle where prescaler == FREQUENCY-1.
REQ-016 On each tick, remaining SHALL decrement; on the tick where remaining == 1, the FSM SHALL enter DONE.
REQ-017 Latency: with req first seen in IDLE at cycle 0 and delay D ≥ 1:
- grant is high from cycle 1;
- the last tick occurs at cycle D*FREQUENCY;
- done[owner] is high in cycle D*FREQUENCY+1 only.
REQ-018 In DONE, the block SHALL pulse done[owner] for exactly one cycle, clear grant in that same cycle, set last_owner = owner, and return to IDLE.
REQ-019 If req[owner] falls while in RUN, the block SHALL abort:
- next state is IDLE with grant cleared;
- no done pulse is issued;
- last_owner is updated.
REQ-020 A req that stays high after done SHALL be treated as a new request at lowest priority relative to the other requesters.
REQ-021 Changes to req or delay of non-owners during RUN SHALL have no effect until the next arbitration in IDLE.
REQ-022 If a new req arrives in the same cycle as DONE, it SHALL NOT be granted before the following IDLE cycle, so there is a minimum of one idle cycle between grants.
REQ-023 tick, done and busy SHALL be low outside RUN and DONE respectively.

Reset
REQ-024 While reset is high, the outputs SHALL be immediately:
- grant = 0, done = 0, busy = 0, tick = 0;
- state = IDLE;
- prescaler = 0, remaining = 0, last_owner = N_REQ-1.
REQ-025 Reset asserted mid-RUN SHALL discard the operation with no done pulse.
REQ-026 After reset is released, arbitration SHALL restart at requester 0.

Structure
REQ-027 A shared package tick_arb_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default constants for FREQUENCY, N_REQ and CNT_W.
REQ-028 The prescaler SHALL be a sub-module tick_prescaler with ports clk, reset, clear and en, and output tick; it is parameterised by FREQUENCY.
REQ-029 The arbiter, FSM and remaining counter SHALL reside in tick_timer_arbiter.

Verification
All scenarios run with FREQUENCY=4, N_REQ=4 and CNT_W=8.
REQ-030 Single request: req=0001, delay0=3 at cycle 0 -> grant=0001 at cycles 1..12, ticks at cycles 4, 8 and 12, done=0001 at cycle 13 only.
REQ-031 Round-robin order: req=1111 held, all delays 1 -> grants in the order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
REQ-032 Zero delay: req=0100, delay2=0 -> grant at cycle 1, done=0100 at cycle 2, no tick.
REQ-033 Abort: req=0010, delay1=5; drop req1 at cycle 6 -> grant=0 from cycle 7, no done, next arbitration starts at requester 2.
REQ-034 Reset mid-RUN: assert reset at cycle 5 of a delay=4 operation -> all outputs 0 in that cycle (asynchronously), no done; after release, req=1001 grants 0001 first.
REQ-035 Non-owner isolation: change delay3 and toggle req3 during requester 0's RUN -> timing of requester 0 unchanged.
